pc_branch_seq: RTL and testbench
================================

PC_BRANCH_SEQ -- requirements
Module: pc_branch_seq

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: value loaded into pc on reset.
REQ-002 Parameter LINK_REG, default 4'd15: register index written by jal.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 clr_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  one-cycle request to execute the instruction on ir.
REQ-006 ir  input  32  instruction word: opcode ir[31:27], Ra ir[26:23], C ir[18:0].
REQ-007 reg_data  input  32  register-file read data, valid one cycle after reg_rd_en.
REQ-008 con_in  input  1  branch-condition result from the condition evaluator, which sees ir_q and the bus.
REQ-009 pc  output  32  program counter.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 con_ff  output  1  latched branch-condition flip-flop.
REQ-013 reg_rd_en  output  1  register read strobe.
REQ-014 reg_addr  output  4  register read index.
REQ-015 ir_q  output  32  latched instruction, driven to the condition evaluator.
REQ-016 link_we  output  1  link-register write strobe.
REQ-017 link_addr  output  4  link write index, equal to LINK_REG.
REQ-018 link_data  output  32  link write data.

Function
REQ-019 Opcodes: br = 5'b10010, jr = 5'b10011, jal = 5'b10100; all other opcodes are non-branch.
REQ-020 FSM states are IDLE, READ, EVAL, UPDATE and DONE; state and all outputs are registered.
REQ-021 In IDLE, a sampled start=1 shall latch ir into ir_q and set pc <= pc+1 (mod 2^32).
- branch opcode: next state is READ.
- non-branch opcode: next state is DONE.
REQ-022 In IDLE with start=0, all state shall hold.
REQ-023 start while busy=1 shall be ignored; requests are neither queued nor counted.
REQ-024 READ: reg_rd_en=1, reg_addr=ir_q[26:23]; next state is EVAL.
REQ-025 EVAL: ra_q <= reg_data.
- br: con_ff <= con_in.
- jr/jal: con_ff unchanged.
- Next state is UPDATE.
REQ-026 UPDATE, br: if con_ff=1, pc <= pc + sign_extend(ir_q[18:0]) mod 2^32; if con_ff=0, pc holds.
REQ-027 UPDATE, jr: pc <= ra_q.
REQ-028 UPDATE, jal: link_we=1 for exactly this cycle, link_data=pc (already incremented), pc <= ra_q.
REQ-029 In jal, link write and pc load occur in the same cycle; link_data shall carry the pre-load pc.
REQ-030 UPDATE always transitions to DONE.
REQ-031 DONE: done=1 for one cycle; next state is IDLE; a start sampled in DONE is ignored.
REQ-032 Latency: branch opcodes assert done in the 4th cycle after the start edge; non-branch opcodes in the 1st cycle after it.
REQ-033 Throughput: a new start is accepted in the first IDLE cycle after done, with no bubble beyond that.
REQ-034 reg_rd_en, link_we and done are each high in at most one state per instruction and low otherwise.

Reset
REQ-035 clr_n=0 shall immediately, without a clock, set state=IDLE and pc=RESET_PC.
REQ-036 clr_n=0 shall immediately clear ir_q, ra_q, con_ff, busy, done, reg_rd_en, reg_addr, link_we and link_data to 0.
REQ-037 Reset asserted mid-instruction shall abort it: no pc update, no link write, no done pulse.
REQ-038 After clr_n rises, the first start shall be accepted on the next clock edge.

Verification
REQ-039 pc=0x10, start with br-zero, C=19'h00005, reg_data=0, con_in=1 -> pc=0x11 after start edge; con_ff=1 in UPDATE; pc=0x16 and done=1 four cycles after start.
REQ-040 Same instruction, con_in=0 -> con_ff=0; pc stays 0x11; done at cycle 4.
REQ-041 pc=0x20, br, C=19'h7FFFE (-2), con_in=1 -> final pc=0x1F.
REQ-042 pc=0x30, jal Ra=R3, reg_data=0x400 -> link_we pulse with link_addr=15 and link_data=0x31; final pc=0x400.
REQ-043 pc=0xFFFF_FFFF, non-branch opcode -> pc=0x0; done one cycle after start; reg_rd_en never asserted.
REQ-044 clr_n low during EVAL of jr -> pc=RESET_PC; no done; a second start pulse during busy is ignored; after release, the next start executes normally.

Source files
------------

// File: rtl/pc_branch_seq.sv
// pc_branch_seq: program-counter sequencer for br/jr/jal with registered FSM outputs
module pc_branch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [3:0]  LINK_REG = 4'd15
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic [31:0] reg_data,
    input  logic        con_in,
    output logic [31:0] pc,
    output logic        busy,
    output logic        done,
    output logic        con_ff,
    output logic        reg_rd_en,
    output logic [3:0]  reg_addr,
    output logic [31:0] ir_q,
    output logic        link_we,
    output logic [3:0]  link_addr,
    output logic [31:0] link_data
);
    localparam logic [4:0] OP_BR = 5'b10010, OP_JR = 5'b10011, OP_JAL = 5'b10100;
    typedef enum logic [2:0] {IDLE, READ, EVAL, UPDATE, DONE} state_t;
    state_t state, state_nx;
    logic [31:0] ra_q, pc_nx;
    logic accept, branch_in;
    assign link_addr = LINK_REG;
    assign accept = (state == IDLE) && start;
    assign branch_in = ir[31:27] inside {OP_BR, OP_JR, OP_JAL};
    always_comb begin
        state_nx = (state == IDLE)   ? (start ? (branch_in ? READ : DONE) : IDLE) :
                   (state == READ)   ? EVAL :
                   (state == EVAL)   ? UPDATE :
                   (state == UPDATE) ? DONE : IDLE;
        pc_nx = pc;
        if (accept)
            pc_nx = pc + 32'd1;
        // only branch opcodes reach UPDATE; non-br ones are jr/jal
        if (state == UPDATE)
            pc_nx = (ir_q[31:27] != OP_BR) ? ra_q :
                    con_ff ? pc + {{13{ir_q[18]}}, ir_q[18:0]} : pc;
    end
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            ir_q      <= '0;
            ra_q      <= '0;
            con_ff    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            reg_rd_en <= 1'b0;
            reg_addr  <= '0;
            link_we   <= 1'b0;
            link_data <= '0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            busy      <= state_nx != IDLE;
            done      <= state_nx == DONE;
            reg_rd_en <= state_nx == READ;
            link_we   <= (state_nx == UPDATE) && (ir_q[31:27] == OP_JAL);
            if (accept) begin
                ir_q     <= ir;
                reg_addr <= ir[26:23];
            end
            if (state == EVAL) begin
                ra_q <= reg_data;
                if (ir_q[31:27] == OP_BR)
                    con_ff <= con_in;
            end
            // pc here is already incremented and not yet reloaded
            if ((state_nx == UPDATE) && (ir_q[31:27] == OP_JAL))
                link_data <= pc;
        end
    end
endmodule

// File: tb/tb_pc_branch_seq.sv
// tb_pc_branch_seq: directed checks of the pc/branch sequencer
module tb_pc_branch_seq;
    localparam logic [31:0] RPC = 32'h10;
    localparam logic [4:0] BR = 5'b10010, JR = 5'b10011, JAL = 5'b10100, NOP = 5'b00001;
    logic clk = 1'b0, clr_n = 1'b0, start = 1'b0, con_in = 1'b0;
    logic [31:0] ir = '0, reg_data = '0;
    logic [31:0] pc, ir_q, link_data;
    logic busy, done, con_ff, reg_rd_en, link_we;
    logic [3:0] reg_addr, link_addr;
    int total = 0, bad = 0;
    pc_branch_seq #(.RESET_PC(RPC), .LINK_REG(4'd15)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .ir(ir), .reg_data(reg_data),
        .con_in(con_in), .pc(pc), .busy(busy), .done(done), .con_ff(con_ff),
        .reg_rd_en(reg_rd_en), .reg_addr(reg_addr), .ir_q(ir_q), .link_we(link_we),
        .link_addr(link_addr), .link_data(link_data)
    );
    always #5 clk = ~clk;
    function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra, input logic [18:0] c);
        return {op, ra, 4'b0, c};
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic go(input logic [31:0] instr, input logic [31:0] rd, input logic c);
        ir = instr;
        reg_data = rd;
        con_in = c;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask
    task automatic set_pc(input logic [31:0] t);
        go(mk(JR, 4'd1, 19'd0), t, 1'b0);
        repeat (3) step();
        chk("set_pc", pc, t);
        step();
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
    initial begin
        repeat (2) step();
        chk("rst_pc", pc, RPC);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ir_q", ir_q, 0);
        chk("rst_rd_en", reg_rd_en, 0);
        chk("rst_link_we", link_we, 0);
        chk("rst_link_data", link_data, 0);
        chk("link_addr", link_addr, 15);
        clr_n = 1'b1;
        // br taken, C=+5 from 0x10
        go(mk(BR, 4'd0, 19'h5), 32'd0, 1'b1);
        chk("br_pc_inc", pc, 32'h11);
        chk("br_busy", busy, 1);
        chk("br_rd_en", reg_rd_en, 1);
        chk("br_reg_addr", reg_addr, 0);
        chk("br_ir_q", ir_q, mk(BR, 4'd0, 19'h5));
        chk("br_done_early", done, 0);
        step();
        chk("br_eval_rd_en", reg_rd_en, 0);
        step();
        chk("br_con_ff", con_ff, 1);
        chk("br_upd_pc", pc, 32'h11);
        step();
        chk("br_final_pc", pc, 32'h16);
        chk("br_done", done, 1);
        step();
        chk("br_done_drop", done, 0);
        chk("br_idle", busy, 0);
        // br not taken
        set_pc(32'h10);
        go(mk(BR, 4'd0, 19'h5), 32'd0, 1'b0);
        step();
        step();
        chk("nt_con_ff", con_ff, 0);
        step();
        chk("nt_pc", pc, 32'h11);
        chk("nt_done", done, 1);
        step();
        // negative offset
        set_pc(32'h20);
        go(mk(BR, 4'd0, 19'h7FFFE), 32'd0, 1'b1);
        repeat (3) step();
        chk("neg_pc", pc, 32'h1F);
        chk("neg_done", done, 1);
        step();
        // jal
        set_pc(32'h30);
        go(mk(JAL, 4'd3, 19'd0), 32'h400, 1'b0);
        chk("jal_reg_addr", reg_addr, 3);
        chk("jal_pc_inc", pc, 32'h31);
        step();
        chk("jal_eval_we", link_we, 0);
        step();
        chk("jal_we", link_we, 1);
        chk("jal_link_data", link_data, 32'h31);
        chk("jal_upd_pc", pc, 32'h31);
        step();
        chk("jal_we_drop", link_we, 0);
        chk("jal_pc", pc, 32'h400);
        chk("jal_done", done, 1);
        chk("jal_con_ff_hold", con_ff, 1);
        step();
        // non-branch wrap, start in DONE ignored, back-to-back start
        set_pc(32'hFFFF_FFFF);
        go(mk(NOP, 4'd2, 19'd0), 32'd0, 1'b0);
        chk("nop_pc_wrap", pc, 0);
        chk("nop_done", done, 1);
        chk("nop_rd_en", reg_rd_en, 0);
        chk("nop_busy", busy, 1);
        ir = mk(BR, 4'd0, 19'h5);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("done_start_busy", busy, 0);
        chk("done_start_pc", pc, 0);
        chk("done_start_ir_q", ir_q, mk(NOP, 4'd2, 19'd0));
        go(mk(NOP, 4'd0, 19'd0), 32'd0, 1'b0);
        chk("b2b_pc", pc, 1);
        chk("b2b_done", done, 1);
        step();
        // jr aborted by reset in EVAL, with a start during busy
        go(mk(JR, 4'd5, 19'd0), 32'h99, 1'b0);
        ir = mk(BR, 4'd0, 19'h5);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_start_ir_q", ir_q, mk(JR, 4'd5, 19'd0));
        chk("busy_start_pc", pc, 2);
        chk("busy_start_rd_en", reg_rd_en, 0);
        #2 clr_n = 1'b0;
        #1;
        chk("abort_pc", pc, RPC);
        chk("abort_busy", busy, 0);
        chk("abort_ir_q", ir_q, 0);
        chk("abort_con_ff", con_ff, 0);
        chk("abort_link_data", link_data, 0);
        repeat (3) step();
        chk("abort_no_done", done, 0);
        chk("abort_pc_hold", pc, RPC);
        clr_n = 1'b1;
        go(mk(BR, 4'd0, 19'h3), 32'd0, 1'b1);
        chk("post_rst_pc", pc, 32'h11);
        chk("post_rst_busy", busy, 1);
        repeat (3) step();
        chk("post_rst_final", pc, 32'h14);
        chk("post_rst_done", done, 1);
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
